mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares one external main-memory port between instruction-cache refills (port I, read-only)
//  and data-cache refills/write-backs (port D, read or write).
//  Sits below instr cache and data_cache in the pipelined core.
//  Each grant is one line burst of BEATS words; the loser's cache keeps stalling its pipe stage.
// PARAMETERS
//  BEATS   4   words per cache line; power of two, >=2
//  ADDR_W  32  byte-address width
//  DATA_W  32  data word width
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       synchronous, active-high reset
//  i_req       in   1       I refill request; held until i_done
//  i_addr      in   ADDR_W  I line address; low bits ignored
//  i_rvalid    out  1       I read beat valid
//  i_rdata     out  DATA_W  I read beat data
//  i_done      out  1       one-cycle pulse: I burst complete
//  d_req       in   1       D request; held until d_done
//  d_we        in   1       1 = write-back burst, 0 = refill; stable while d_req
//  d_addr      in   ADDR_W  D line address; low bits ignored
//  d_wdata     in   DATA_W  D write beat; advances on d_wready
//  d_wready    out  1       D write beat consumed this cycle
//  d_rvalid    out  1       D read beat valid
//  d_rdata     out  DATA_W  D read beat data
//  d_done      out  1       one-cycle pulse: D burst complete
//  beat_o      out  BW      current beat index; BW = $clog2(BEATS)
//  mem_req     out  1       memory beat request
//  mem_we      out  1       memory write
//  mem_addr    out  ADDR_W  beat byte address
//  mem_wdata   out  DATA_W  write data (= d_wdata)
//  mem_ready   in   1       beat accepted (write) / mem_rdata valid (read)
//  mem_rdata   in   DATA_W  read data
// BEHAVIOUR
//  - Reset: state IDLE, beat=0, owner=I.
//    All outputs 0: req, we, valid, ready, done, data, addr.
//  - Reset mid-burst: abort immediately with no done pulse.
//    Requesters must re-request after reset.
//  - IDLE: arbitrate among i_req/d_req sampled this cycle. If granted:
//    latch owner, base={addr[ADDR_W-1:OFF],OFF'b0} (OFF=$clog2(BEATS*DATA_W/8)),
//    we (I forces 0), beat=0; then go to BURST. No request: stay in IDLE.
//  - BURST: mem_req=1; mem_addr=base+beat*(DATA_W/8); mem_we=latched we.
//    On mem_ready: owner rvalid=1 with rdata=mem_rdata (read), or d_wready=1 (write); beat++.
//    On mem_ready at beat==BEATS-1: go to DONE, beat wraps to 0.
//    mem_ready=0 holds all outputs (wait states unbounded).
//  - DONE: owner done=1 for exactly one cycle; go to IDLE. Requests are ignored in DONE,
//    so a requester dropping req after done is never re-granted.
//  - Minimum occupancy: 1 (IDLE) + BEATS + 1 (DONE) cycles; back-to-back grants allowed.
//  - Non-owner outputs stay 0 throughout.
//    Owner req/addr/we changes mid-burst are ignored (latched values used).
//  - Request dropped mid-burst: protocol violation; burst still completes.
//  - rdata is only meaningful when rvalid is 1; it is driven 0 otherwise.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin. On simultaneous requests, grant the port not served last.
//    last_owner resets to I, so D wins the first tie.
//  MEM_ARB_RR_EN undefined: fixed priority, D always wins ties.
//    A MEM-stage stall freezes the whole pipe. I can starve; accepted.
// STRUCTURE
//  Package mem_arb_pkg: state enum {IDLE,BURST,DONE}, owner enum {OWN_I,OWN_D},
//  BW/OFF localparam helpers.
//  Sub-module mem_arb_pick: combinational (i_req,d_req,last_owner) -> (grant_valid,grant_owner).
//  The macro is confined to this sub-module.
//  FSM, beat counter, and address/data muxing stay in mem_arbiter.
// TESTING
//  1. I only: i_addr=0x104, mem_ready held 1, rdata=beat+0xA0 ->
//     mem_addr 0x100,104,108,10C; i_rvalid x4 (0xA0..A3); i_done at cycle 6.
//  2. D write: d_we=1, d_addr=0x2008, mem_ready every 2nd cycle ->
//     4 d_wready pulses aligned to mem_ready; mem_we=1; one d_done.
//  3. Tie, both req same cycle -> D served first; I granted after D's DONE.
//     Without MEM_ARB_RR_EN, a D re-request in DONE still wins the next tie.
//  4. RR: both requests held for 4 bursts -> grant order D,I,D,I.
//  5. Reset asserted at beat 2 -> next cycle all outputs 0, no done pulse; new i_req granted normally.
//  6. mem_ready=0 for 10 cycles mid-burst -> mem_addr/beat_o stable; no valid/ready pulses.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the memory arbiter.
// Optional feature macro used by this block: MEM_ARB_RR_EN (round-robin tie-break).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Width of the beat counter.
    function automatic int calc_bw(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    // Number of low address bits covered by one line.
    function automatic int calc_off(input int beats, input int data_w);
        return $clog2(beats * data_w / 8);
    endfunction

    // Shift that turns a beat index into a byte offset.
    function automatic int calc_bsh(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache refill ports, the arbiter and main memory.
// The arbiter uses the slave modport; the cache/memory side uses master.
// Optional feature macro of this block: MEM_ARB_RR_EN (affects the arbiter only).
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int BEATS  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BW = calc_bw(BEATS);

    // instruction-cache port
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              i_done;
    // data-cache port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_wready;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    // status and memory port
    logic [BW-1:0]     beat_o;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        output i_rvalid, i_rdata, i_done, d_wready, d_rvalid, d_rdata, d_done,
               beat_o, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        input  i_rvalid, i_rdata, i_done, d_wready, d_rvalid, d_rdata, d_done,
               beat_o, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Grant selection between the I and D refill ports.
// MEM_ARB_RR_EN defined: ties go to the port not served last.
// MEM_ARB_RR_EN undefined: ties always go to D.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   i_req_i,
    input  logic   d_req_i,
    input  owner_t last_owner_i,
    output logic   grant_valid_o,
    output owner_t grant_owner_o
);

    owner_t tie_owner;

`ifdef MEM_ARB_RR_EN
    assign tie_owner = (last_owner_i == OWN_I) ? OWN_D : OWN_I;
`else
    // Fixed priority never looks at history; keep the input visibly consumed.
    logic unused_last_owner;
    assign unused_last_owner = last_owner_i;
    assign tie_owner         = OWN_D;
`endif

    // Single requester wins outright; a tie defers to the configured policy.
    always_comb begin
        grant_valid_o = i_req_i | d_req_i;
        grant_owner_o = OWN_I;
        if (i_req_i && d_req_i) begin
            grant_owner_o = tie_owner;
        end else if (d_req_i) begin
            grant_owner_o = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between I-cache refills and D-cache refills/write-backs.
// Each grant is a BEATS-word line burst: IDLE (arbitrate) -> BURST -> DONE (one-cycle done).
// Optional feature macro: MEM_ARB_RR_EN selects round-robin tie-breaking (see mem_arb_pick).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BEATS  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)
(
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);

    localparam int BW  = calc_bw(BEATS);
    localparam int OFF = calc_off(BEATS, DATA_W);
    localparam int BSH = calc_bsh(DATA_W);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF) - ADDR_W'(1));
    localparam logic [BW-1:0]     LAST_BEAT = BW'(BEATS - 1);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_owner_q, last_owner_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              we_q, we_d;

    logic              grant_valid;
    owner_t            grant_owner;

    mem_arb_pick u_pick (
        .i_req_i       (bus.i_req),
        .d_req_i       (bus.d_req),
        .last_owner_i  (last_owner_q),
        .grant_valid_o (grant_valid),
        .grant_owner_o (grant_owner)
    );

    // State and burst context registers; reset aborts any burst silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_I;
            beat_q       <= '0;
            base_q       <= '0;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_q       <= beat_d;
            base_q       <= base_d;
            we_q         <= we_d;
        end
    end

    // Next-state: grant in IDLE, count accepted beats in BURST, single DONE cycle.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_d       = beat_q;
        base_d       = base_q;
        we_d         = we_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d      = grant_owner;
                    last_owner_d = grant_owner;
                    base_d       = ((grant_owner == OWN_D) ? bus.d_addr : bus.i_addr) & LINE_MASK;
                    // The I port is read-only, so its bursts never write.
                    we_d         = (grant_owner == OWN_D) && bus.d_we;
                    beat_d       = '0;
                    state_d      = BURST;
                end
            end
            BURST: begin
                if (bus.mem_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = DONE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                    end
                end
            end
            DONE: begin
                // Requests seen here are deliberately ignored.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    logic              in_burst;
    logic              beat_fire;
    logic              own_d;
    logic [ADDR_W-1:0] beat_off;

    assign in_burst  = (state_q == BURST);
    assign beat_fire = in_burst && bus.mem_ready;
    assign own_d     = (owner_q == OWN_D);
    assign beat_off  = ADDR_W'(beat_q) << BSH;

    // Outputs decode from the registered state; anything not owned stays 0.
    always_comb begin
        bus.mem_req   = in_burst;
        bus.mem_we    = in_burst && we_q;
        bus.mem_addr  = in_burst ? (base_q + beat_off) : '0;
        bus.mem_wdata = (in_burst && we_q) ? bus.d_wdata : '0;
        bus.i_rvalid  = beat_fire && !own_d && !we_q;
        bus.d_rvalid  = beat_fire &&  own_d && !we_q;
        bus.d_wready  = beat_fire &&  own_d &&  we_q;
        bus.i_rdata   = (beat_fire && !own_d && !we_q) ? bus.mem_rdata : '0;
        bus.d_rdata   = (beat_fire &&  own_d && !we_q) ? bus.mem_rdata : '0;
        bus.i_done    = (state_q == DONE) && !own_d;
        bus.d_done    = (state_q == DONE) &&  own_d;
        bus.beat_o    = beat_q;
    end

endmodule
